out_fm_fifo_to_mem: RTL and testbench

OUT_FM_FIFO_TO_MEM -- requirements
Module: out_fm_fifo_to_mem

---
 rtl/out_fm_fifo_to_mem_pkg.sv | 21 ++
 rtl/out_fm_fifo_to_mem_if.sv | 36 +++
 rtl/out_fm_fifo_to_mem_nest3_counter.sv | 67 ++++++
 rtl/out_fm_fifo_to_mem.sv | 162 ++++++++++++++++
 tb/tb_out_fm_fifo_to_mem.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/out_fm_fifo_to_mem_pkg.sv
// Shared types and constants for the output feature-map write-back engine.
// Holds the FSM state encoding and the word-to-byte scaling used for addressing.
package out_fm_fifo_to_mem_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
  } state_e;

  localparam int DW_DEFAULT     = 32;
  localparam int BYTES_PER_WORD = DW_DEFAULT / 8;

  // Byte stride of one data word for an arbitrary word width.
  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/out_fm_fifo_to_mem_if.sv
// FIFO read port and Avalon-MM single-beat write port of the write-back engine.
// The master modport is the engine side; the slave modport is the FIFO/memory side.
interface out_fm_fifo_to_mem_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          fifo_pop;
  logic          fifo_empty;
  logic [DW-1:0] data_from_fifo;
  logic [AW-1:0] avm_address;
  logic          avm_write;
  logic [DW-1:0] avm_writedata;
  logic          avm_waitrequest;

  modport master (
    output fifo_pop,
    input  fifo_empty,
    input  data_from_fifo,
    output avm_address,
    output avm_write,
    output avm_writedata,
    input  avm_waitrequest
  );

  modport slave (
    input  fifo_pop,
    output fifo_empty,
    output data_from_fifo,
    input  avm_address,
    input  avm_write,
    input  avm_writedata,
    output avm_waitrequest
  );

endinterface

// File: rtl/out_fm_fifo_to_mem_nest3_counter.sv
// Three-level nested element counter: tc innermost, then tr, then tn outermost.
// last flags the final element of the tile so the caller can finish after consuming it.
module nest3_counter #(
  parameter int CW = 32,
  parameter int Tn = 8,
  parameter int Tr = 16,
  parameter int Tc = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] tc,
  output logic [CW-1:0] tr,
  output logic [CW-1:0] tn,
  output logic          last
);

  localparam logic [CW-1:0] TC_MAX = CW'(Tc - 1);
  localparam logic [CW-1:0] TR_MAX = CW'(Tr - 1);
  localparam logic [CW-1:0] TN_MAX = CW'(Tn - 1);

  logic [CW-1:0] tc_q, tc_d;
  logic [CW-1:0] tr_q, tr_d;
  logic [CW-1:0] tn_q, tn_d;

  always_comb begin
    tc_d = tc_q;
    tr_d = tr_q;
    tn_d = tn_q;
    if (clr) begin
      tc_d = '0;
      tr_d = '0;
      tn_d = '0;
    end else if (en) begin
      if (tc_q == TC_MAX) begin
        tc_d = '0;
        if (tr_q == TR_MAX) begin
          tr_d = '0;
          tn_d = (tn_q == TN_MAX) ? '0 : tn_q + 1'b1;
        end else begin
          tr_d = tr_q + 1'b1;
        end
      end else begin
        tc_d = tc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tc_q <= '0;
      tr_q <= '0;
      tn_q <= '0;
    end else begin
      tc_q <= tc_d;
      tr_q <= tr_d;
      tn_q <= tn_d;
    end
  end

  assign tc   = tc_q;
  assign tr   = tr_q;
  assign tn   = tn_q;
  assign last = (tc_q == TC_MAX) && (tr_q == TR_MAX) && (tn_q == TN_MAX);

endmodule

// File: rtl/out_fm_fifo_to_mem.sv
// Drains one output feature-map tile from a FIFO and writes each in-bounds element
// to memory over Avalon-MM; out-of-bounds elements are popped and dropped.
module out_fm_fifo_to_mem
  import out_fm_fifo_to_mem_pkg::*;
#(
  parameter int CW = 32,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int N  = 32,
  parameter int R  = 64,
  parameter int C  = 32,
  parameter int Tn = 8,
  parameter int Tr = 16,
  parameter int Tc = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 done,
  input  logic [CW-1:0]        tile_base_n,
  input  logic [CW-1:0]        tile_base_row,
  input  logic [CW-1:0]        tile_base_col,
  input  logic [AW-1:0]        mem_base_addr,
  out_fm_fifo_to_mem_if.master bus
);

  localparam logic [CW:0]   N_L   = (CW+1)'(N);
  localparam logic [CW:0]   R_L   = (CW+1)'(R);
  localparam logic [CW:0]   C_L   = (CW+1)'(C);
  localparam logic [AW-1:0] RC_A  = AW'(R * C);
  localparam logic [AW-1:0] C_A   = AW'(C);
  localparam logic [AW-1:0] BPW_A = AW'(bytes_per_word(DW));

  state_e        state_q, state_d;
  logic [CW-1:0] base_n_q, base_n_d;
  logic [CW-1:0] base_row_q, base_row_d;
  logic [CW-1:0] base_col_q, base_col_d;
  logic [AW-1:0] mem_base_q, mem_base_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          cnt_clr, cnt_en, cnt_last;
  logic [CW-1:0] tc, tr, tn;
  logic          pop_raw, write_raw, done_raw;

  logic [CW:0]   n_sum, row_sum, col_sum;
  logic [AW-1:0] n_a, row_a, col_a, elem_addr;
  logic          elem_legal;

  nest3_counter #(
    .CW (CW),
    .Tn (Tn),
    .Tr (Tr),
    .Tc (Tc)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc   (tc),
    .tr   (tr),
    .tn   (tn),
    .last (cnt_last)
  );

  // Bounds are checked one bit wider so a tile near the top of the range cannot wrap into legality.
  always_comb begin
    n_sum      = {1'b0, base_n_q}   + {1'b0, tn};
    row_sum    = {1'b0, base_row_q} + {1'b0, tr};
    col_sum    = {1'b0, base_col_q} + {1'b0, tc};
    elem_legal = (n_sum < N_L) && (row_sum < R_L) && (col_sum < C_L);
    n_a        = AW'(base_n_q)   + AW'(tn);
    row_a      = AW'(base_row_q) + AW'(tr);
    col_a      = AW'(base_col_q) + AW'(tc);
    elem_addr  = mem_base_q + (n_a * RC_A + row_a * C_A + col_a) * BPW_A;
  end

  // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    base_n_d   = base_n_q;
    base_row_d = base_row_q;
    base_col_d = base_col_q;
    mem_base_d = mem_base_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    pop_raw    = 1'b0;
    write_raw  = 1'b0;
    done_raw   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_n_d   = tile_base_n;
          base_row_d = tile_base_row;
          base_col_d = tile_base_col;
          mem_base_d = mem_base_addr;
          cnt_clr    = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (!bus.fifo_empty) begin
          pop_raw = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        addr_d  = elem_addr;
        wdata_d = bus.data_from_fifo;
        if (elem_legal) begin
          state_d = WRITE;
        end else begin
          cnt_en  = 1'b1;
          state_d = cnt_last ? FINISH : FETCH;
        end
      end
      WRITE: begin
        write_raw = 1'b1;
        if (!bus.avm_waitrequest) begin
          cnt_en  = 1'b1;
          state_d = cnt_last ? FINISH : FETCH;
        end
      end
      FINISH: begin
        done_raw = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_n_q   <= '0;
      base_row_q <= '0;
      base_col_q <= '0;
      mem_base_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      base_n_q   <= base_n_d;
      base_row_q <= base_row_d;
      base_col_q <= base_col_d;
      mem_base_q <= mem_base_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Strobes are masked while reset is held so no pop or write leaks out of an abandoned tile.
  assign bus.fifo_pop      = pop_raw   & ~rst;
  assign bus.avm_write     = write_raw & ~rst;
  assign done              = done_raw  & ~rst;
  assign bus.avm_address   = addr_q;
  assign bus.avm_writedata = wdata_q;

endmodule

// File: tb/tb_out_fm_fifo_to_mem.sv
// Directed bench for out_fm_fifo_to_mem on a 4x4x4 map with 2x2x2 tiles,
// using a small FIFO model and an Avalon write logger.
module tb_out_fm_fifo_to_mem;

  localparam int CW = 32;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          done;
  logic [CW-1:0] tb_n, tb_row, tb_col;
  logic [AW-1:0] mem_base;

  out_fm_fifo_to_mem_if #(.AW(AW), .DW(DW)) bus_if ();

  out_fm_fifo_to_mem #(
    .CW(CW), .AW(AW), .DW(DW),
    .N(4), .R(4), .C(4), .Tn(2), .Tr(2), .Tc(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .done          (done),
    .tile_base_n   (tb_n),
    .tile_base_row (tb_row),
    .tile_base_col (tb_col),
    .mem_base_addr (mem_base),
    .bus           (bus_if)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo_mem [$];
  logic [AW-1:0] wr_addr [$];
  logic [DW-1:0] wr_data [$];
  int push_total = 0;
  int pop_total  = 0;
  int bad_pops   = 0;
  int done_cnt   = 0;
  int checks     = 0;
  int errors     = 0;
  logic [AW-1:0] exp_addr [8];

  assign bus_if.fifo_empty = (push_total == pop_total);

  always @(posedge clk) begin
    if (bus_if.fifo_pop) begin
      if (fifo_mem.size() == 0) bad_pops <= bad_pops + 1;
      else bus_if.data_from_fifo <= fifo_mem.pop_front();
      pop_total <= pop_total + 1;
    end
    if (bus_if.avm_write && !bus_if.avm_waitrequest) begin
      wr_addr.push_back(bus_if.avm_address);
      wr_data.push_back(bus_if.avm_writedata);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [DW-1:0] base, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      fifo_mem.push_back(base + DW'(i));
      push_total++;
    end
  endtask

  task automatic pulse_start(input logic [CW-1:0] n, input logic [CW-1:0] row,
                             input logic [CW-1:0] col, input logic [AW-1:0] base);
    @(negedge clk);
    tb_n = n; tb_row = row; tb_col = col; mem_base = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0 = done_cnt;
    int i  = 0;
    while (done_cnt == d0 && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk({tag, " done_seen"}, 64'(done_cnt - d0), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_writes(input int n, input string tag);
    int i = 0;
    while (wr_addr.size() < n && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk({tag, " reach_writes"}, 64'(wr_addr.size() >= n), 64'd1);
  endtask

  // Full-tile check for origin (0,0,0) at base 0x1000.
  task automatic check_origin0(input string tag, input logic [DW-1:0] dbase,
                               input int pops0, input int done0);
    chk({tag, " nwrites"}, 64'(wr_addr.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < wr_addr.size()) begin
        chk($sformatf("%s addr%0d", tag, i), 64'(wr_addr[i]), 64'(exp_addr[i]));
        chk($sformatf("%s data%0d", tag, i), 64'(wr_data[i]), 64'(dbase + DW'(i)));
      end
    end
    chk({tag, " pops"}, 64'(pop_total - pops0), 64'd8);
    chk({tag, " dones"}, 64'(done_cnt - done0), 64'd1);
  endtask

  initial begin
    int pops0, done0, stall_pops, stall_writes;
    exp_addr[0] = 32'h1000; exp_addr[1] = 32'h1004;
    exp_addr[2] = 32'h1010; exp_addr[3] = 32'h1014;
    exp_addr[4] = 32'h1040; exp_addr[5] = 32'h1044;
    exp_addr[6] = 32'h1050; exp_addr[7] = 32'h1054;
    rst = 1'b1; start = 1'b0;
    tb_n = '0; tb_row = '0; tb_col = '0; mem_base = '0;
    bus_if.avm_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset fifo_pop", 64'(bus_if.fifo_pop), 64'd0);
    chk("reset avm_write", 64'(bus_if.avm_write), 64'd0);
    chk("reset avm_address", 64'(bus_if.avm_address), 64'd0);
    chk("reset avm_writedata", 64'(bus_if.avm_writedata), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    rst = 1'b0;

    // Basic tile at origin (0,0,0).
    wr_addr.delete(); wr_data.delete();
    preload(32'h1111_0000, 0, 8);
    pops0 = pop_total; done0 = done_cnt;
    pulse_start(0, 0, 0, 32'h1000);
    wait_done("t1");
    check_origin0("t1", 32'h1111_0000, pops0, done0);

    // Corner tile: only element [3][3][3] is in bounds.
    wr_addr.delete(); wr_data.delete();
    preload(32'h2222_0000, 0, 8);
    pops0 = pop_total; done0 = done_cnt;
    pulse_start(3, 3, 3, 32'h1000);
    wait_done("t2");
    chk("t2 nwrites", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() > 0) begin
      chk("t2 addr", 64'(wr_addr[0]), 64'h10FC);
      chk("t2 data", 64'(wr_data[0]), 64'h2222_0000);
    end
    chk("t2 pops", 64'(pop_total - pops0), 64'd8);
    chk("t2 dones", 64'(done_cnt - done0), 64'd1);

    // Waitrequest held for 5 cycles on the third write.
    wr_addr.delete(); wr_data.delete();
    preload(32'h3333_0000, 0, 8);
    pops0 = pop_total; done0 = done_cnt;
    pulse_start(0, 0, 0, 32'h1000);
    wait_writes(2, "t3");
    bus_if.avm_waitrequest = 1'b1;
    for (int i = 0; i < 400 && !bus_if.avm_write; i++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3 stall%0d write", k), 64'(bus_if.avm_write), 64'd1);
      chk($sformatf("t3 stall%0d addr", k), 64'(bus_if.avm_address), 64'h1010);
      chk($sformatf("t3 stall%0d data", k), 64'(bus_if.avm_writedata), 64'h3333_0002);
      chk($sformatf("t3 stall%0d pops", k), 64'(pop_total - pops0), 64'd3);
      @(negedge clk);
    end
    bus_if.avm_waitrequest = 1'b0;
    chk("t3 cycle6 write", 64'(bus_if.avm_write), 64'd1);
    chk("t3 cycle6 nwrites", 64'(wr_addr.size()), 64'd2);
    @(negedge clk);
    chk("t3 after nwrites", 64'(wr_addr.size()), 64'd3);
    wait_done("t3");
    check_origin0("t3", 32'h3333_0000, pops0, done0);

    // FIFO runs dry for 10 cycles after four elements.
    wr_addr.delete(); wr_data.delete();
    preload(32'h4444_0000, 0, 4);
    pops0 = pop_total; done0 = done_cnt;
    pulse_start(0, 0, 0, 32'h1000);
    wait_writes(4, "t4");
    stall_pops = 0; stall_writes = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus_if.fifo_pop) stall_pops++;
      if (bus_if.avm_write) stall_writes++;
    end
    chk("t4 empty pops", 64'(stall_pops), 64'd0);
    chk("t4 empty writes", 64'(stall_writes), 64'd0);
    chk("t4 empty nwrites", 64'(wr_addr.size()), 64'd4);
    preload(32'h4444_0000, 4, 4);
    wait_done("t4");
    check_origin0("t4", 32'h4444_0000, pops0, done0);

    // Reset in the middle of a tile, then a fresh tile.
    wr_addr.delete(); wr_data.delete();
    preload(32'h5555_0000, 0, 8);
    done0 = done_cnt;
    pulse_start(0, 0, 0, 32'h1000);
    wait_writes(3, "t5");
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("t5 rst%0d fifo_pop", k), 64'(bus_if.fifo_pop), 64'd0);
      chk($sformatf("t5 rst%0d avm_write", k), 64'(bus_if.avm_write), 64'd0);
      chk($sformatf("t5 rst%0d avm_address", k), 64'(bus_if.avm_address), 64'd0);
      chk($sformatf("t5 rst%0d avm_writedata", k), 64'(bus_if.avm_writedata), 64'd0);
      chk($sformatf("t5 rst%0d done", k), 64'(done), 64'd0);
    end
    rst = 1'b0;
    fifo_mem.delete();
    push_total = pop_total;
    repeat (5) @(negedge clk);
    chk("t5 no partial done", 64'(done_cnt - done0), 64'd0);
    wr_addr.delete(); wr_data.delete();
    preload(32'h6666_0000, 0, 8);
    pops0 = pop_total; done0 = done_cnt;
    pulse_start(0, 0, 0, 32'h1000);
    wait_done("t5");
    check_origin0("t5", 32'h6666_0000, pops0, done0);

    // A second start mid-tile must be ignored.
    wr_addr.delete(); wr_data.delete();
    preload(32'h7777_0000, 0, 8);
    pops0 = pop_total; done0 = done_cnt;
    pulse_start(0, 0, 0, 32'h1000);
    wait_writes(2, "t6");
    pulse_start(3, 3, 3, 32'h2000);
    wait_done("t6");
    repeat (20) @(negedge clk);
    check_origin0("t6", 32'h7777_0000, pops0, done0);

    chk("pop while empty", 64'(bad_pops), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
